// File: rtl/fml_arb2.sv
// fml_arb2: two-master round-robin arbiter in front of a single FML burst slave
module fml_arb2 #(
    parameter int adr_width = 27,
    parameter int burst_len = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [adr_width-1:0] m0_adr,
    input  logic                 m0_stb,
    input  logic                 m0_we,
    input  logic [7:0]           m0_sel,
    input  logic [63:0]          m0_di,
    output logic                 m0_ack,
    input  logic [adr_width-1:0] m1_adr,
    input  logic                 m1_stb,
    input  logic                 m1_we,
    input  logic [7:0]           m1_sel,
    input  logic [63:0]          m1_di,
    output logic                 m1_ack,
    output logic [63:0]          m_do,
    output logic [adr_width-1:0] s_adr,
    output logic                 s_stb,
    output logic                 s_we,
    input  logic                 s_ack,
    output logic [7:0]           s_sel,
    output logic [63:0]          s_di,
    input  logic [63:0]          s_do
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    localparam logic [2:0] LAST_BEAT = 3'(burst_len - 1);
    state_t     state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic [2:0] cnt_q, cnt_d;
    logic       g_stb;
    assign m_do = s_do;
    // state, grant, round-robin history and beat counter registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
    // next-state, arbitration and slave/master routing
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        g_stb   = grant_q ? m1_stb : m0_stb;
        s_stb   = 1'b0;
        s_adr   = '0;
        s_we    = 1'b0;
        s_sel   = '0;
        s_di    = '0;
        m0_ack  = 1'b0;
        m1_ack  = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_stb || m1_stb) begin
                    grant_d = (m0_stb && m1_stb) ? ~last_q : m1_stb;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                s_stb  = g_stb;
                s_adr  = grant_q ? m1_adr : m0_adr;
                s_we   = grant_q ? m1_we : m0_we;
                s_sel  = grant_q ? m1_sel : m0_sel;
                s_di   = grant_q ? m1_di : m0_di;
                m0_ack = ~grant_q & g_stb & s_ack;
                m1_ack = grant_q & g_stb & s_ack;
                if (!g_stb) begin
                    state_d = IDLE;
                end else if (s_ack) begin
                    state_d = DATA;
                    cnt_d   = 3'd0;
                    last_d  = grant_q;
                end
            end
            DATA: begin
                s_sel = grant_q ? m1_sel : m0_sel;
                s_di  = grant_q ? m1_di : m0_di;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_BEAT) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fml_arb2.sv
// tb_fml_arb2: randomized bench for fml_arb2 against a cycle-numbered transaction model
module tb_fml_arb2;
    localparam int AW = 27;
    localparam int BL = 4;
    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m_adr [2];
    logic          m_stb [2];
    logic          m_we  [2];
    logic [7:0]    m_sel [2];
    logic [63:0]   m_di  [2];
    logic          m0_ack, m1_ack;
    logic [63:0]   m_do, s_do, s_di;
    logic [AW-1:0] s_adr;
    logic          s_stb, s_we, s_ack;
    logic [7:0]    s_sel;
    int n_chk = 0, n_pass = 0;
    int owner = -1, last = 1, ack_at = 0, cyc = 0;
    bit in_addr = 1'b0;
    bit got [2] = '{1'b0, 1'b0};
    logic          e_stb, e_we;
    logic          e_ack [2];
    logic [AW-1:0] e_adr;
    logic [7:0]    e_sel;
    logic [63:0]   e_di;
    int who_q[$], at_q[$];

    always #5 clk = ~clk;

    fml_arb2 #(.adr_width(AW), .burst_len(BL)) dut (
        .sys_clk(clk), .sys_rst(rst),
        .m0_adr(m_adr[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_sel(m_sel[0]), .m0_di(m_di[0]), .m0_ack(m0_ack),
        .m1_adr(m_adr[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_sel(m_sel[1]), .m1_di(m_di[1]), .m1_ack(m1_ack),
        .m_do(m_do), .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_ack(s_ack),
        .s_sel(s_sel), .s_di(s_di), .s_do(s_do)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
    endtask

    task automatic new_req(input int i);
        m_adr[i] = AW'($urandom);
        m_we[i]  = 1'($urandom_range(1));
        m_sel[i] = 8'($urandom);
    endtask

    task automatic step(input bit directed);
        @(posedge clk);
        #1;
        rst = !directed && $urandom_range(199) == 0;
        for (int i = 0; i < 2; i++) begin
            m_di[i] = {$urandom, $urandom};
            if (directed) m_stb[i] = 1'b1;
            else if (m_stb[i] && got[i]) begin
                m_stb[i] = 1'($urandom_range(1));
                if (m_stb[i]) new_req(i);
            end else if (!m_stb[i]) begin
                if ($urandom_range(2) == 0) begin
                    m_stb[i] = 1'b1;
                    new_req(i);
                end
            end else if ($urandom_range(49) == 0) m_stb[i] = 1'b0;
        end
        s_do  = {$urandom, $urandom};
        e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_sel = '0; e_di = '0;
        e_ack[0] = 1'b0; e_ack[1] = 1'b0;
        if (owner >= 0) begin
            e_sel = m_sel[owner];
            e_di  = m_di[owner];
            if (in_addr) begin
                e_stb = m_stb[owner];
                e_adr = m_adr[owner];
                e_we  = m_we[owner];
            end
        end
        s_ack = directed ? e_stb : (e_stb && $urandom_range(2) == 0);
        if (owner >= 0) e_ack[owner] = in_addr && e_stb && s_ack;
        @(negedge clk);
        chk("s_stb", 64'(s_stb), 64'(e_stb));
        chk("s_adr", 64'(s_adr), 64'(e_adr));
        chk("s_we", 64'(s_we), 64'(e_we));
        chk("s_sel", 64'(s_sel), 64'(e_sel));
        chk("s_di", s_di, e_di);
        chk("m0_ack", 64'(m0_ack), 64'(e_ack[0]));
        chk("m1_ack", 64'(m1_ack), 64'(e_ack[1]));
        chk("m_do", m_do, s_do);
        got[0] = e_ack[0];
        got[1] = e_ack[1];
        if (directed && (m0_ack || m1_ack)) begin
            who_q.push_back(m1_ack ? 1 : 0);
            at_q.push_back(cyc);
        end
        if (rst) begin
            owner = -1; last = 1; in_addr = 1'b0;
        end else if (owner < 0) begin
            if (m_stb[0] || m_stb[1]) begin
                owner   = (m_stb[0] && m_stb[1]) ? 1 - last : (m_stb[1] ? 1 : 0);
                in_addr = 1'b1;
            end
        end else if (in_addr) begin
            if (!e_stb) owner = -1;
            else if (s_ack) begin
                in_addr = 1'b0; ack_at = cyc; last = owner;
            end
        end else if (cyc == ack_at + BL) owner = -1;
        cyc++;
    endtask

    initial begin
        rst = 1'b1; s_ack = 1'b0; s_do = '0;
        for (int i = 0; i < 2; i++) begin
            m_stb[i] = 1'b0; m_we[i] = 1'b0; m_adr[i] = '0; m_sel[i] = '0; m_di[i] = '0;
        end
        repeat (3) @(posedge clk);
        for (int k = 0; k < 30; k++) step(1'b1);
        chk("tie_acks", 64'(who_q.size() >= 4), 64'd1);
        for (int k = 0; k < 4 && k < who_q.size(); k++) chk("tie_order", 64'(who_q[k]), 64'(k % 2));
        for (int k = 1; k < 4 && k < at_q.size(); k++) chk("b2b_gap", 64'(at_q[k] - at_q[k-1]), 64'(BL + 2));
        for (int i = 0; i < 2; i++) m_stb[i] = 1'b0;
        for (int k = 0; k < 3000; k++) step(1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
